// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// baud divisor helper used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous serial line plus a
// falling-edge detector on the synchronised copy.
module uart_rx_sync (
    input  logic sclk,
    input  logic s_rst,
    input  logic rs232_rx,
    output logic rx_s,
    output logic fall
);

    logic r1;
    logic r2;
    logic r3;

    // Reset to the idle-high line level so leaving reset never looks like a start edge.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r1 <= 1'b1;
            r2 <= 1'b1;
            r3 <= 1'b1;
        end else begin
            r1 <= rs232_rx;
            r2 <= r1;
            r3 <= r2;
        end
    end

    assign rx_s = r2;
    assign fall = r3 & ~r2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: detects the start edge, samples each bit at mid-bit and
// presents the byte with single-cycle rx_flag / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic                   sclk,
    input  logic                   s_rst,
    input  logic                   rs232_rx,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_flag,
    output logic                   frame_err,
    output logic                   rx_busy
);

    localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BAUD_DIV / 2 - 1);

    logic                   rx_s;
    logic                   fall;
    uart_state_t            state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [3:0]             bit_cnt;
    logic [UART_DATA_W-1:0] shift_reg;
    logic                   mid_bit;

    uart_rx_sync u_sync (
        .sclk     (sclk),
        .s_rst    (s_rst),
        .rs232_rx (rs232_rx),
        .rx_s     (rx_s),
        .fall     (fall)
    );

    assign mid_bit = (baud_cnt == CNT_MID);

    // Output strobes: rx_flag and frame_err are each high for exactly one
    // cycle and never together; there is no back-pressure, the consumer must
    // capture rx_data in the rx_flag cycle. rx_busy mirrors state != IDLE.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_flag   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_flag   <= 1'b0;
            frame_err <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= (baud_cnt == CNT_MAX) ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        baud_cnt <= '0;
                        rx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (mid_bit) begin
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        shift_reg <= {rx_s, shift_reg[UART_DATA_W-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid-stop gives half a bit of margin for a back-to-back start edge.
                    if (mid_bit) begin
                        if (rx_s) begin
                            rx_data <= shift_reg;
                            rx_flag <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 100 cycles/bit: frame table plus hand-written
// glitch, break and reset-mid-frame sequences.
module tb_uart_rx;

    localparam int BIT_CYC = 100;

    logic       sclk;
    logic       s_rst;
    logic       rs232_rx;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       frame_err;
    logic       rx_busy;

    int total;
    int bad;
    int flag_cnt;
    int err_cnt;
    logic prev_flag;
    logic prev_err;
    logic prev_busy;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_flags;
        int         exp_errs;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    uart_rx #(
        .CLK_HZ (100_000_000),
        .BAUD   (1_000_000)
    ) dut (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .rs232_rx  (rs232_rx),
        .rx_data   (rx_data),
        .rx_flag   (rx_flag),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    // clock / reset
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_bit(input logic b, input int n);
        rs232_rx = b;
        repeat (n) @(negedge sclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CYC);
        drive_bit(stop, BIT_CYC);
    endtask

    // scoreboard / monitor
    always @(negedge sclk) begin
        if (!s_rst) begin
            if (rx_flag || frame_err) begin
                check("flag_err_exclusive", {31'd0, rx_flag & frame_err}, 32'd0);
                check("busy_low_on_strobe", {31'd0, rx_busy}, 32'd0);
                check("busy_before_strobe", {31'd0, prev_busy}, 32'd1);
            end
            if (rx_flag) begin
                flag_cnt++;
                check("flag_width", {31'd0, prev_flag}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_flag", 32'd1, 32'd0);
                end else begin
                    check("rx_data_on_flag", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frame_err) begin
                err_cnt++;
                check("err_width", {31'd0, prev_err}, 32'd0);
            end
        end
        prev_flag = rx_flag;
        prev_err  = frame_err;
        prev_busy = rx_busy;
    end

    initial begin
        int busy_cyc;
        total     = 0;
        bad       = 0;
        flag_cnt  = 0;
        err_cnt   = 0;
        prev_flag = 1'b0;
        prev_err  = 1'b0;
        prev_busy = 1'b0;
        rs232_rx  = 1'b1;
        s_rst     = 1'b1;

        // frames sent back to back; last one has a bad stop bit
        vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'hA3, 1'b1, 1, 0, 8'hA3};
        vecs[4] = '{8'h0F, 1'b1, 1, 0, 8'h0F};
        vecs[5] = '{8'h3C, 1'b0, 0, 1, 8'h0F};

        repeat (4) @(negedge sclk);
        s_rst = 1'b0;
        @(negedge sclk);
        check("reset_rx_data", {24'd0, rx_data}, 32'h0);
        check("reset_rx_flag", {31'd0, rx_flag}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        repeat (20) @(negedge sclk);

        for (int v = 0; v < 6; v++) begin
            flag_cnt = 0;
            err_cnt  = 0;
            if (vecs[v].stop) exp_q.push_back(vecs[v].exp_data);
            send_frame(vecs[v].data, vecs[v].stop);
            check($sformatf("vec%0d_flags", v), flag_cnt, vecs[v].exp_flags);
            check($sformatf("vec%0d_errs", v), err_cnt, vecs[v].exp_errs);
            check($sformatf("vec%0d_rx_data", v), {24'd0, rx_data}, {24'd0, vecs[v].exp_data});
        end

        // line held low after the framing error: no new frame may start
        flag_cnt = 0;
        err_cnt  = 0;
        drive_bit(1'b0, 5 * BIT_CYC);
        check("break_busy", {31'd0, rx_busy}, 32'd0);
        check("break_strobes", flag_cnt + err_cnt, 32'd0);
        drive_bit(1'b1, 3 * BIT_CYC);

        // glitch: 30 cycles low is rejected at the start-bit midpoint
        busy_cyc = 0;
        rs232_rx = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c == 30) rs232_rx = 1'b1;
            @(negedge sclk);
            if (rx_busy) busy_cyc++;
        end
        check("glitch_busy_cycles", busy_cyc, 32'd50);
        check("glitch_strobes", flag_cnt + err_cnt, 32'd0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'h0F);

        // reset during bit 4 of 0xFF, then a clean 0x81
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT_CYC);
        drive_bit(1'b1, BIT_CYC / 2);
        check("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
        s_rst = 1'b1;
        @(negedge sclk);
        s_rst = 1'b0;
        check("rst_mid_rx_data", {24'd0, rx_data}, 32'h0);
        check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_mid_flags", {30'd0, rx_flag, frame_err}, 32'd0);
        drive_bit(1'b1, 5 * BIT_CYC);
        check("rst_mid_no_strobe", flag_cnt + err_cnt, 32'd0);
        check("rst_mid_busy_after", {31'd0, rx_busy}, 32'd0);

        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        check("post_reset_flags", flag_cnt, 32'd1);
        check("post_reset_rx_data", {24'd0, rx_data}, 32'h81);
        drive_bit(1'b1, 50);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
